// File: rtl/ofdm_frame_rx_deframer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ofdm_frame_rx_deframer_pkg
// Purpose  : Shared constants for the OFDM receive deframer: symbol geometry,
//            frame-FSM state encodings, FCH field bit positions and a helper
//            that assembles the split frame-size field.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ofdm_frame_rx_deframer_pkg;

  localparam int c_data_size        = 16;
  localparam int c_fft_size         = 256;
  localparam int c_cp_len           = 8;
  localparam int c_max_data_symbols = 255;

  // Frame FSM encodings
  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_symbol = 2'd1;
  localparam logic [1:0] c_st_done   = 2'd2;

  // FCH field bit positions
  localparam int c_b0_rep_bit  = 7;   // byte0: repetition[0]
  localparam int c_b0_rsvd_bit = 6;   // byte0: reserved, must be 0
  localparam int c_b1_rep_bit  = 0;   // byte1: repetition[1]

  // FCH byte counter values
  localparam logic [1:0] c_fch_byte0 = 2'd0;
  localparam logic [1:0] c_fch_byte1 = 2'd1;
  localparam logic [1:0] c_fch_byte2 = 2'd2;
  localparam logic [1:0] c_fch_full  = 2'd3;   // all three bytes seen

  // Frame size is split: low nibble in byte1[7:4], high nibble in byte2[3:0]
  function automatic logic [7:0] f_size_join(input logic [3:0] hi, input logic [3:0] lo);
    return {hi, lo};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ofdm_frame_rx_deframer_fch_parser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ofdm_frame_rx_deframer_fch_parser
// Purpose  : Counts the three demapped FCH bytes, latches the frame
//            parameters and flags reserved-bit / oversize errors.
// Ports    : clk, reset (async, active-low)
//            i_clear      - clears byte counter and o_fch_valid
//            i_enable     - bytes accepted only while high
//            i_fch_valid / i_fch_data - demapped FCH byte stream
//            o_frame_size, o_coding, o_repetition, o_subchannel_bitmap
//            o_fch_valid  - level, parameters latched
//            o_byte2_ok   - comb: clean third byte accepted this cycle
//            o_parse_error- comb: accepted byte is malformed
//            o_size_next  - comb: frame size including the byte on the bus
// Revision : 1.0 - initial release
// ============================================================================
module ofdm_frame_rx_deframer_fch_parser
  import ofdm_frame_rx_deframer_pkg::*;
#(
  parameter int MAX_DATA_SYMBOLS = c_max_data_symbols
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic       i_fch_valid,
  input  logic [7:0] i_fch_data,
  output logic [7:0] o_frame_size,
  output logic [2:0] o_coding,
  output logic [1:0] o_repetition,
  output logic [5:0] o_subchannel_bitmap,
  output logic       o_fch_valid,
  output logic       o_byte2_ok,
  output logic       o_parse_error,
  output logic [7:0] o_size_next
);

  localparam logic [8:0] c_max = 9'(MAX_DATA_SYMBOLS);

  logic [1:0] r_byte_cnt;
  logic       w_accept;
  logic       w_rsvd0;
  logic       w_rsvd2;
  logic       w_too_big;

  // Bytes beyond the third are silently dropped by saturating the counter
  assign w_accept      = i_enable && i_fch_valid && (r_byte_cnt != c_fch_full);
  assign o_size_next   = f_size_join(i_fch_data[3:0], o_frame_size[3:0]);
  assign w_rsvd0       = (r_byte_cnt == c_fch_byte0) && i_fch_data[c_b0_rsvd_bit];
  assign w_rsvd2       = (r_byte_cnt == c_fch_byte2) && (i_fch_data[7:4] != 4'd0);
  assign w_too_big     = (r_byte_cnt == c_fch_byte2) && ({1'b0, o_size_next} > c_max);
  assign o_parse_error = w_accept && (w_rsvd0 || w_rsvd2 || w_too_big);
  assign o_byte2_ok    = w_accept && (r_byte_cnt == c_fch_byte2) && !o_parse_error;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_byte_cnt          <= c_fch_byte0;
      o_frame_size        <= 8'd0;
      o_coding            <= 3'd0;
      o_repetition        <= 2'd0;
      o_subchannel_bitmap <= 6'd0;
      o_fch_valid         <= 1'b0;
    end else if (i_clear) begin
      // Parameter fields stay held; only the handshake state restarts
      r_byte_cnt  <= c_fch_byte0;
      o_fch_valid <= 1'b0;
    end else if (w_accept) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      case (r_byte_cnt)
        c_fch_byte0: begin
          o_repetition[0]     <= i_fch_data[c_b0_rep_bit];
          o_subchannel_bitmap <= i_fch_data[5:0];
        end
        c_fch_byte1: begin
          o_frame_size[3:0] <= i_fch_data[7:4];
          o_coding          <= i_fch_data[3:1];
          o_repetition[1]   <= i_fch_data[c_b1_rep_bit];
        end
        default: begin
          o_frame_size[7:4] <= i_fch_data[3:0];
          o_fch_valid       <= !o_parse_error;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ofdm_frame_rx_deframer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ofdm_frame_rx_deframer
// Purpose  : Strips the cyclic prefix from each received OFDM symbol,
//            forwards the useful samples with symbol framing, and tracks the
//            frame length decoded from the FCH to end the frame.
// Ports    : clk, reset (async, active-low)
//            i_sync, in_valid, in_data_i/q   - sample stream from timing sync
//            fch_valid, fch_data             - FCH bytes from BPSK demapper
//            out_valid, out_data_i/q, out_first, out_last,
//            out_symbol_idx, out_fch_symbol  - useful samples to the FFT
//            o_frame_size, o_coding, o_repetition, o_subchannel_bitmap,
//            o_fch_valid                     - latched frame parameters
//            done_receive, fch_error         - one-cycle frame end pulses
//            o_state                         - FSM state for debug
// Revision : 1.0 - initial release
// ============================================================================
module ofdm_frame_rx_deframer
  import ofdm_frame_rx_deframer_pkg::*;
#(
  parameter int DATA_SIZE        = c_data_size,
  parameter int SYMBOLS_SIZE     = c_fft_size,
  parameter int CP_LENGHT        = c_cp_len,
  parameter int MAX_DATA_SYMBOLS = c_max_data_symbols
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_sync,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data_i,
  input  logic [DATA_SIZE-1:0] in_data_q,
  input  logic                 fch_valid,
  input  logic [7:0]           fch_data,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data_i,
  output logic [DATA_SIZE-1:0] out_data_q,
  output logic                 out_first,
  output logic                 out_last,
  output logic [7:0]           out_symbol_idx,
  output logic                 out_fch_symbol,
  output logic [7:0]           o_frame_size,
  output logic [2:0]           o_coding,
  output logic [1:0]           o_repetition,
  output logic [5:0]           o_subchannel_bitmap,
  output logic                 o_fch_valid,
  output logic                 done_receive,
  output logic                 fch_error,
  output logic [1:0]           o_state
);

  localparam int              c_sym_total = SYMBOLS_SIZE + CP_LENGHT;
  localparam int              c_cw        = $clog2(c_sym_total);
  localparam logic [c_cw-1:0] c_cnt_last  = c_cw'(c_sym_total - 1);
  localparam logic [c_cw-1:0] c_cnt_first = c_cw'(CP_LENGHT);
  localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);

  logic [1:0]      r_state;
  logic [c_cw-1:0] r_sample_cnt;
  logic [7:0]      r_sym_cnt;

  logic       w_start, w_in_sym, w_samp, w_last, w_useful;
  logic       w_fch_ok, w_done, w_no_fch, w_err, w_clear;
  logic       w_byte2_ok, w_parse_err;
  logic [7:0] w_size_next, w_size_now;
  logic [8:0] w_total, w_completed;

  assign w_start  = (r_state == c_st_idle) && i_sync && in_valid;
  assign w_in_sym = (r_state == c_st_symbol);
  assign w_samp   = w_in_sym && in_valid;
  assign w_last   = w_samp && (r_sample_cnt == c_cnt_last);
  assign w_useful = w_samp && (r_sample_cnt >= c_cnt_first);

  // A third byte arriving this cycle counts as already latched so that a
  // coincident last sample and byte2 resolve to a single completion.
  assign w_fch_ok    = o_fch_valid || w_byte2_ok;
  assign w_size_now  = w_byte2_ok ? w_size_next : o_frame_size;
  assign w_total     = {1'b0, w_size_now} + 9'd1;
  assign w_completed = {1'b0, r_sym_cnt} + {8'd0, w_last};
  // ">=" also covers a late FCH that arrives after enough symbols passed
  assign w_done      = w_in_sym && w_fch_ok && (w_completed >= w_total);
  assign w_no_fch    = w_last && (r_sym_cnt == 8'd1) && !w_fch_ok;
  assign w_err       = w_in_sym && (w_parse_err || w_no_fch);
  assign w_clear     = w_start || w_err;
  assign o_state     = r_state;

  ofdm_frame_rx_deframer_fch_parser #(
    .MAX_DATA_SYMBOLS (MAX_DATA_SYMBOLS)
  ) u_fch_parser (
    .clk                 (clk),
    .reset               (reset),
    .i_clear             (w_clear),
    .i_enable            (r_state != c_st_idle),
    .i_fch_valid         (fch_valid),
    .i_fch_data          (fch_data),
    .o_frame_size        (o_frame_size),
    .o_coding            (o_coding),
    .o_repetition        (o_repetition),
    .o_subchannel_bitmap (o_subchannel_bitmap),
    .o_fch_valid         (o_fch_valid),
    .o_byte2_ok          (w_byte2_ok),
    .o_parse_error       (w_parse_err),
    .o_size_next         (w_size_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= c_st_idle;
      r_sample_cnt   <= '0;
      r_sym_cnt      <= 8'd0;
      out_valid      <= 1'b0;
      out_data_i     <= '0;
      out_data_q     <= '0;
      out_first      <= 1'b0;
      out_last       <= 1'b0;
      out_symbol_idx <= 8'd0;
      out_fch_symbol <= 1'b0;
      done_receive   <= 1'b0;
      fch_error      <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      out_first    <= 1'b0;
      out_last     <= 1'b0;
      done_receive <= 1'b0;
      fch_error    <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_start) begin
            r_state      <= c_st_symbol;
            r_sample_cnt <= c_cnt_one;     // sync sample is CP sample 0
            r_sym_cnt    <= 8'd0;
          end
        end
        c_st_symbol: begin
          if (w_err) begin
            fch_error <= 1'b1;
            r_state   <= c_st_idle;
          end else begin
            if (w_samp) begin
              r_sample_cnt <= w_last ? '0 : r_sample_cnt + c_cnt_one;
              if (w_last) r_sym_cnt <= r_sym_cnt + 8'd1;
              // A completion mid-symbol truncates it: that sample is dropped
              if (w_useful && (!w_done || w_last)) begin
                out_valid      <= 1'b1;
                out_first      <= (r_sample_cnt == c_cnt_first);
                out_last       <= w_last;
                out_data_i     <= in_data_i;
                out_data_q     <= in_data_q;
                out_symbol_idx <= r_sym_cnt;
                out_fch_symbol <= (r_sym_cnt == 8'd0);
              end
            end
            if (w_done) begin
              done_receive <= 1'b1;
              r_state      <= c_st_done;
            end
          end
        end
        c_st_done: r_state <= c_st_idle;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire
